serial_add_ctrl: RTL

- Bit-serial addition controller.
- Time-shares one full_adder cell to add two WIDTH-bit operands, LSB first, one bit per clock.
- Owns operand shift registers, carry flop, bit counter and a start/done handshake.
- Sits between a requesting datapath and the single 1-bit full_adder instance.

---
 rtl/serial_add_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller time-sharing one full_adder cell
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADD_SUB_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] op_a, op_b;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_carry;
  logic             sub_mode;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_mode = sub;
`else
  assign sub_mode = 1'b0;
`endif

  full_adder u_fa (op_a[0], op_b[0], carry, fa_sum, fa_carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          // Subtraction is a + ~b + 1; cout then reads as "no borrow".
          op_a  <= a;
          op_b  <= sub_mode ? ~b : b;
          carry <= sub_mode ? 1'b1 : cin;
          cnt   <= '0;
          sum   <= '0;
          cout  <= 1'b0;
        end
        RUN: begin
          sum   <= {fa_sum, sum[WIDTH-1:1]};
          carry <= fa_carry;
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_CNT) cout <= fa_carry;
        end
        default: ;
      endcase
    end
  end
endmodule
